// File: rtl/tx_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tx_frame_sequencer
//
// Sits in front of the scrambler + rate-1/2 convolutional encoder transmitter.
// Two requesters compete for the transmitter. The winner is chosen round-robin
// on a tie. The winner's scrambler seed and pad length are handed to the
// transmitter with a one-cycle load pulse. The sequencer then streams the
// winner's frame bits serially, followed by the encoder flush zeros (tail) and
// the pad zeros. Only one frame is in flight at a time.
//
// Ports
//   Clk, reset            clock (rising edge) and synchronous active-high reset
//   req[1:0]              level requests, sampled only while idle
//   len0/1, seed0/1,      per-requester frame length (bits), scrambler seed,
//   pad0/1                pad length; captured at grant time
//   bit_in0/1             current frame bit of each requester
//   bit_rd[1:0]           one-hot pull strobe; a bit is consumed at the edge
//                         that ends a cycle in which its strobe is high
//   gnt[1:0]              one-hot grant, held for the whole frame
//   tx_load               one-cycle pulse: transmitter latches tx_seed/tx_pad_len
//   tx_seed, tx_pad_len   seed and pad length of the granted requester
//   tx_data/_valid/_tail  registered serial stream to the transmitter
//   busy                  high whenever a frame is being handled
//   done[1:0]             one-cycle completion pulse for the granted requester
// -----------------------------------------------------------------------------
module tx_frame_sequencer #(
    parameter int LEN_W     = 12,
    parameter int PAD_W     = 8,
    parameter int TAIL_BITS = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [6:0]       seed0,
    input  logic [6:0]       seed1,
    input  logic [PAD_W-1:0] pad0,
    input  logic [PAD_W-1:0] pad1,
    input  logic             bit_in0,
    input  logic             bit_in1,
    output logic [1:0]       bit_rd,
    output logic [1:0]       gnt,
    output logic             tx_load,
    output logic [6:0]       tx_seed,
    output logic [PAD_W-1:0] tx_pad_len,
    output logic             tx_data,
    output logic             tx_data_valid,
    output logic             tx_tail,
    output logic             busy,
    output logic [1:0]       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DATA,
        S_TAIL,
        S_PAD,
        S_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [LEN_W-1:0] cnt_reg;     // shared down-counter: len, then tail, then pad
    logic             ptr_reg;     // requester favoured on the next tie
    logic             win;         // requester that wins arbitration this cycle
    logic             cnt_last;

    // Sole requester wins outright; on a tie the pointer decides.
    always_comb begin
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ptr_reg;
        endcase
    end

    assign cnt_last = (cnt_reg == LEN_W'(1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req != 2'b00) state_next = S_LOAD;
            // The counter already holds the granted length here; zero skips DATA.
            S_LOAD: state_next = (cnt_reg == '0) ? S_TAIL : S_DATA;
            S_DATA: if (cnt_last) state_next = S_TAIL;
            S_TAIL: if (cnt_last) state_next = (tx_pad_len != '0) ? S_PAD : S_DONE;
            S_PAD:  if (cnt_last) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        bit_rd  = 2'b00;
        done    = 2'b00;
        tx_load = 1'b0;
        busy    = 1'b1;
        case (state_reg)
            S_IDLE: busy    = 1'b0;
            S_LOAD: tx_load = 1'b1;
            S_DATA: bit_rd  = gnt;
            S_DONE: done    = gnt;
            default: ;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            ptr_reg       <= 1'b0;
            gnt           <= 2'b00;
            tx_seed       <= '0;
            tx_pad_len    <= '0;
            tx_data       <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_tail       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        gnt        <= win ? 2'b10 : 2'b01;
                        ptr_reg    <= ~win;
                        cnt_reg    <= win ? len1  : len0;
                        tx_seed    <= win ? seed1 : seed0;
                        tx_pad_len <= win ? pad1  : pad0;
                    end
                end
                S_LOAD: begin
                    if (cnt_reg == '0) begin
                        cnt_reg <= LEN_W'(TAIL_BITS);
                    end
                end
                S_DATA: begin
                    tx_data       <= gnt[1] ? bit_in1 : bit_in0;
                    tx_data_valid <= 1'b1;
                    tx_tail       <= 1'b0;
                    cnt_reg       <= cnt_last ? LEN_W'(TAIL_BITS) : cnt_reg - 1'b1;
                end
                S_TAIL: begin
                    tx_data       <= 1'b0;
                    tx_data_valid <= 1'b1;
                    tx_tail       <= 1'b1;
                    cnt_reg       <= cnt_last ? LEN_W'(tx_pad_len) : cnt_reg - 1'b1;
                end
                S_PAD: begin
                    tx_data       <= 1'b0;
                    tx_data_valid <= 1'b1;
                    tx_tail       <= 1'b0;
                    cnt_reg       <= cnt_reg - 1'b1;
                end
                S_DONE: begin
                    tx_data       <= 1'b0;
                    tx_data_valid <= 1'b0;
                    tx_tail       <= 1'b0;
                    gnt           <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
module tb_tx_frame_sequencer;

    localparam int LEN_W = 12;
    localparam int PAD_W = 8;

    logic             Clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [LEN_W-1:0] len0 = '0;
    logic [LEN_W-1:0] len1 = '0;
    logic [6:0]       seed0 = '0;
    logic [6:0]       seed1 = '0;
    logic [PAD_W-1:0] pad0 = '0;
    logic [PAD_W-1:0] pad1 = '0;
    logic             bit_in0 = 1'b0;
    logic             bit_in1 = 1'b0;
    logic [1:0]       bit_rd;
    logic [1:0]       gnt;
    logic             tx_load;
    logic [6:0]       tx_seed;
    logic [PAD_W-1:0] tx_pad_len;
    logic             tx_data;
    logic             tx_data_valid;
    logic             tx_tail;
    logic             busy;
    logic [1:0]       done;

    int n_assert = 0;
    int n_fail   = 0;

    // per-frame observations gathered by run_frame
    int         fr_valid;
    int         fr_tail;
    int         fr_rd;
    logic [1:0] fr_gnt;
    logic [6:0] fr_seed;
    logic       fr_load;
    logic [1:0] fr_done;
    logic       fr_done_valid;
    logic       got_done;

    logic       bits1 [4];

    tx_frame_sequencer #(.LEN_W(LEN_W), .PAD_W(PAD_W), .TAIL_BITS(6)) dut (
        .Clk(Clk), .reset(reset), .req(req),
        .len0(len0), .len1(len1), .seed0(seed0), .seed1(seed1),
        .pad0(pad0), .pad1(pad1), .bit_in0(bit_in0), .bit_in1(bit_in1),
        .bit_rd(bit_rd), .gnt(gnt), .tx_load(tx_load), .tx_seed(tx_seed),
        .tx_pad_len(tx_pad_len), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_tail(tx_tail), .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Starts in IDLE with req already driven; returns in the DONE cycle.
    task automatic run_frame(input int budget, input bit mutate);
        fr_valid = 0; fr_tail = 0; fr_rd = 0;
        fr_done = 2'b00; fr_done_valid = 1'b0; got_done = 1'b0;
        tick;
        fr_gnt  = gnt;
        fr_seed = tx_seed;
        fr_load = tx_load;
        if (mutate) begin
            len0 = 12'd7; len1 = 12'd7;
            seed0 = ~seed0; seed1 = ~seed1;
            pad0 = 8'd9; pad1 = 8'd9;
            req = 2'b00;
        end
        for (int c = 0; c < budget && !got_done; c++) begin
            bit_in0 = c[0];
            bit_in1 = ~c[0];
            tick;
            if (tx_data_valid) fr_valid++;
            if (tx_tail) fr_tail++;
            if (bit_rd != 2'b00) fr_rd++;
            if (done != 2'b00) begin
                got_done      = 1'b1;
                fr_done       = done;
                fr_done_valid = tx_data_valid;
            end
        end
        chk("frame_done_seen", 32'(got_done), 32'd1);
    endtask

    initial begin
        bits1[0] = 1'b1; bits1[1] = 1'b0; bits1[2] = 1'b1; bits1[3] = 1'b1;

        // ---------------- reset state
        reset = 1'b1;
        tick; tick;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_load", 32'(tx_load), 32'd0);
        chk("rst_seed", 32'(tx_seed), 32'd0);
        chk("rst_pad", 32'(tx_pad_len), 32'd0);
        chk("rst_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_tail", 32'(tx_tail), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bit_rd", 32'(bit_rd), 32'd0);
        reset = 1'b0;

        // ---------------- frame 1: detailed timing, len 4, pad 2
        req = 2'b01; len0 = 12'd4; seed0 = 7'b1011101; pad0 = 8'd2;
        tick;   // LOAD
        req = 2'b00;
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_load", 32'(tx_load), 32'd1);
        chk("t1_seed", 32'(tx_seed), 32'h5D);
        chk("t1_pad", 32'(tx_pad_len), 32'd2);
        chk("t1_load_bit_rd", 32'(bit_rd), 32'd0);
        chk("t1_load_valid", 32'(tx_data_valid), 32'd0);
        tick;   // DATA cycle 1
        chk("t1_data1_valid", 32'(tx_data_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t1_bit_rd", 32'(bit_rd), 32'd1);
            chk("t1_no_load", 32'(tx_load), 32'd0);
            bit_in0 = bits1[i];
            tick;
            chk("t1_data_valid", 32'(tx_data_valid), 32'd1);
            chk("t1_data", 32'(tx_data), 32'(bits1[i]));
            chk("t1_data_tail", 32'(tx_tail), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            chk("t1_tail_rd", 32'(bit_rd), 32'd0);
            tick;
            chk("t1_tail_valid", 32'(tx_data_valid), 32'd1);
            chk("t1_tail_data", 32'(tx_data), 32'd0);
            chk("t1_tail_flag", 32'(tx_tail), 32'd1);
        end
        for (int i = 0; i < 2; i++) begin
            chk("t1_pad_done", 32'(done), 32'd0);
            tick;
            chk("t1_pad_valid", 32'(tx_data_valid), 32'd1);
            chk("t1_pad_data", 32'(tx_data), 32'd0);
            chk("t1_pad_tail", 32'(tx_tail), 32'd0);
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_busy", 32'(busy), 32'd1);
        tick;
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_valid", 32'(tx_data_valid), 32'd0);
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        chk("t1_idle_done", 32'(done), 32'd0);

        // ---------------- round robin with both requesting
        reset = 1'b1; tick; reset = 1'b0;
        req = 2'b11; len0 = 12'd3; len1 = 12'd3; pad0 = 8'd0; pad1 = 8'd0;
        seed0 = 7'h11; seed1 = 7'h22;
        run_frame(100, 1'b0);
        chk("rr1_gnt", 32'(fr_gnt), 32'd1);
        chk("rr1_valid", 32'(fr_valid), 32'd9);
        chk("rr1_done", 32'(fr_done), 32'd1);
        tick;
        run_frame(100, 1'b0);
        chk("rr2_gnt", 32'(fr_gnt), 32'd2);
        chk("rr2_seed", 32'(fr_seed), 32'h22);
        chk("rr2_valid", 32'(fr_valid), 32'd9);
        chk("rr2_done", 32'(fr_done), 32'd2);
        tick;
        run_frame(100, 1'b0);
        chk("rr3_gnt", 32'(fr_gnt), 32'd1);
        chk("rr3_valid", 32'(fr_valid), 32'd9);
        req = 2'b00;
        tick;
        chk("rr_idle_valid", 32'(tx_data_valid), 32'd0);

        // ---------------- zero length, zero pad
        req = 2'b01; len0 = 12'd0; pad0 = 8'd0;
        run_frame(100, 1'b0);
        req = 2'b00;
        chk("z_gnt", 32'(fr_gnt), 32'd1);
        chk("z_load", 32'(fr_load), 32'd1);
        chk("z_valid", 32'(fr_valid), 32'd6);
        chk("z_tail", 32'(fr_tail), 32'd6);
        chk("z_bit_rd", 32'(fr_rd), 32'd0);
        chk("z_done_valid", 32'(fr_done_valid), 32'd1);
        tick;

        // ---------------- requester 1 alone, then tie favours requester 0
        req = 2'b10; len1 = 12'd2; pad1 = 8'd1; seed1 = 7'h33;
        run_frame(100, 1'b0);
        chk("solo1_gnt", 32'(fr_gnt), 32'd2);
        chk("solo1_valid", 32'(fr_valid), 32'd9);
        chk("solo1_rd", 32'(fr_rd), 32'd2);
        tick;
        req = 2'b11; len0 = 12'd5; pad0 = 8'd1; seed0 = 7'h2A;
        run_frame(100, 1'b1);
        chk("tie_gnt", 32'(fr_gnt), 32'd1);
        chk("tie_valid", 32'(fr_valid), 32'd12);
        chk("tie_seed_end", 32'(tx_seed), 32'h2A);
        chk("tie_pad_end", 32'(tx_pad_len), 32'd1);
        req = 2'b00;
        tick;

        // ---------------- reset in DATA cycle 3 of a len 10 frame
        req = 2'b01; len0 = 12'd10; pad0 = 8'd0;
        tick;           // LOAD
        req = 2'b00;
        tick; tick; tick;   // DATA cycles 1..3
        chk("abort_in_data", 32'(bit_rd), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_valid", 32'(tx_data_valid), 32'd0);
        chk("abort_data", 32'(tx_data), 32'd0);
        chk("abort_seed", 32'(tx_seed), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bit_rd", 32'(bit_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        req = 2'b11; len0 = 12'd1; len1 = 12'd1;
        run_frame(100, 1'b0);
        req = 2'b00;
        chk("post_rst_gnt", 32'(fr_gnt), 32'd1);
        chk("post_rst_valid", 32'(fr_valid), 32'd7);
        tick;

        // ---------------- maximum length and pad
        req = 2'b01; len0 = 12'd4095; pad0 = 8'd255;
        run_frame(5000, 1'b0);
        req = 2'b00;
        chk("max_valid", 32'(fr_valid), 32'd4356);
        chk("max_rd", 32'(fr_rd), 32'd4095);
        chk("max_done", 32'(fr_done), 32'd1);
        chk("max_done_valid", 32'(fr_done_valid), 32'd1);
        tick;
        chk("max_after_valid", 32'(tx_data_valid), 32'd0);
        chk("max_after_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
